// File: rtl/video_pkg.sv
// Shared 640x480@60 raster timing constants and pixel types
// for the PPU video front end.
package video_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [9:0] H_LAST = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST = V_TOTAL - 10'd1;

    localparam logic [9:0] VBLANK_END_LINE = 10'd522;
    localparam logic [9:0] SWAP_PRIME_LINE = 10'd524;

    typedef logic [23:0] rgb888_t;

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster counters and the registered
// frame-control pulses for the PPU.
module raster_counter
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       rowram_swap,
    output logic       vblank_start,
    output logic       vblank_end
);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       swap_q, swap_d;
    logic       vstart_q, vstart_d;
    logic       vend_q, vend_d;

    always_comb begin
        h_wrap   = (hcount_q == H_LAST);
        hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
        v_next   = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        vcount_d = h_wrap ? v_next : vcount_q;
        // Pulses are decided on the last pixel of the preceding line.
        swap_d   = h_wrap &&
                   ((v_next == SWAP_PRIME_LINE) ||
                    ((v_next != 10'd0) && (v_next < V_ACTIVE) &&
                     !v_next[0]));
        vstart_d = h_wrap && (v_next == V_ACTIVE);
        vend_d   = h_wrap && (v_next == VBLANK_END_LINE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= 10'd0;
            vcount_q <= V_ACTIVE;
            swap_q   <= 1'b0;
            vstart_q <= 1'b0;
            vend_q   <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            swap_q   <= swap_d;
            vstart_q <= vstart_d;
            vend_q   <= vend_d;
        end
    end

    assign hcount       = hcount_q;
    assign vcount       = vcount_q;
    assign rowram_swap  = swap_q;
    assign vblank_start = vstart_q;
    assign vblank_end   = vend_q;

endmodule

// File: rtl/hdmi_scanout.sv
// 640x480 scanout: row RAM -> palette RAM -> RGB888 with
// 2x2 pixel doubling and sync/DE aligned to the pixel pipe.
module hdmi_scanout
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [8:0]  rowram_rdaddr,
    input  logic [9:0]  rowram_rddata,
    output logic [8:0]  palram_rdaddr,
    input  logic [63:0] palram_rddata,
    output logic        rowram_swap,
    output logic        vblank_start,
    output logic        vblank_end,
    output logic [23:0] hdmi_rgb,
    output logic        hdmi_hsync,
    output logic        hdmi_vsync,
    output logic        hdmi_de
);

    logic [9:0] hcount, vcount;
    logic       de_c, hs_c, vs_c;
    logic       sel_q, sel_d;
    logic [2:0] de_q, de_d;
    logic [2:0] hs_q, hs_d;
    logic [2:0] vs_q, vs_d;
    rgb888_t    rgb_q, rgb_d;
    rgb888_t    pix;
    logic       unused_pal;

    raster_counter u_raster (
        .clk          (clk),
        .rst          (rst),
        .hcount       (hcount),
        .vcount       (vcount),
        .rowram_swap  (rowram_swap),
        .vblank_start (vblank_start),
        .vblank_end   (vblank_end)
    );

    assign unused_pal = ^{palram_rddata[63:56], palram_rddata[31:24]};

    always_comb begin
        de_c = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
        hs_c = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
        vs_c = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
        rowram_rdaddr = (hcount < H_ACTIVE) ? hcount[9:1] : 9'd0;
        palram_rdaddr = rowram_rddata[9:1];
        sel_d = rowram_rddata[0];
        pix   = sel_q ? palram_rddata[55:32] : palram_rddata[23:0];
        // de_q[1] is the DE of the pixel now leaving the palette RAM.
        rgb_d = de_q[1] ? pix : 24'd0;
        de_d  = {de_q[1:0], de_c};
        hs_d  = {hs_q[1:0], hs_c};
        vs_d  = {vs_q[1:0], vs_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= 1'b0;
            rgb_q <= 24'd0;
            de_q  <= 3'b000;
            hs_q  <= 3'b111;
            vs_q  <= 3'b111;
        end else begin
            sel_q <= sel_d;
            rgb_q <= rgb_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign hdmi_rgb   = rgb_q;
    assign hdmi_de    = de_q[2];
    assign hdmi_hsync = hs_q[2];
    assign hdmi_vsync = vs_q[2];

endmodule

// File: tb/tb_hdmi_scanout.sv
// Self-checking bench: raster-position model plus pinned literals.
module tb_hdmi_scanout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  rowram_rdaddr;
    logic [9:0]  rowram_rddata = '0;
    logic [8:0]  palram_rdaddr;
    logic [63:0] palram_rddata = '0;
    logic        rowram_swap, vblank_start, vblank_end;
    logic [23:0] hdmi_rgb;
    logic        hdmi_hsync, hdmi_vsync, hdmi_de;

    always #5 clk = ~clk;

    hdmi_scanout dut (
        .clk           (clk),
        .rst           (rst),
        .rowram_rdaddr (rowram_rdaddr),
        .rowram_rddata (rowram_rddata),
        .palram_rdaddr (palram_rdaddr),
        .palram_rddata (palram_rddata),
        .rowram_swap   (rowram_swap),
        .vblank_start  (vblank_start),
        .vblank_end    (vblank_end),
        .hdmi_rgb      (hdmi_rgb),
        .hdmi_hsync    (hdmi_hsync),
        .hdmi_vsync    (hdmi_vsync),
        .hdmi_de       (hdmi_de)
    );

    // Synchronous RAM models; both palette halves are nonzero.
    always @(posedge clk) begin
        rowram_rddata <= {rowram_rdaddr, rowram_rdaddr[0]};
        palram_rddata <= {8'h00, 8'h80, 7'd0, palram_rdaddr,
                          8'h00, 8'h40, 7'd0, palram_rdaddr};
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycles since the last reset edge; 0 means counters at (0,480).
    int n = 0;
    bit started = 0;
    always @(posedge clk) begin
        if (rst) begin
            n <= 0;
            started <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    function automatic void pos_of(input int k, output int h,
                                   output int v);
        int p;
        p = (480 * 800 + k) % 420000;
        h = p % 800;
        v = p / 800;
    endfunction

    function automatic logic [23:0] color_of(input int x);
        int col;
        col = x / 2;
        return (col % 2 == 1) ? (24'h800000 | col) : (24'h400000 | col);
    endfunction

    int phase = 0;
    int vend_n[2] = '{-1, -1};
    int swap_cnt[2] = '{0, 0};
    int first_de_n = -1;
    int first_hs_fall_n = -1;
    int vs_low_cnt = 0;
    int hs_low_line1 = 0;
    int de_line0 = 0;
    logic [23:0] rgb_x0 = 'x;
    logic [23:0] rgb_x3 = 'x;
    logic prev_hs = 1'b1;

    always @(negedge clk) begin
        int h, v, hd, vd;
        bit e_swap, e_vs, e_ve, e_de, e_hs, e_vsy;
        logic [23:0] e_rgb;
        #2;
        if (started) begin
            pos_of(n, h, v);
            e_swap = (n > 0) && (h == 0) &&
                     (v == 524 || (v >= 2 && v <= 478 && v % 2 == 0));
            e_vs = (n > 0) && (h == 0) && (v == 480);
            e_ve = (n > 0) && (h == 0) && (v == 522);
            if (n >= 3) begin
                pos_of(n - 3, hd, vd);
                e_de  = (hd < 640) && (vd < 480);
                e_hs  = !(hd >= 656 && hd < 752);
                e_vsy = !(vd >= 490 && vd < 492);
                e_rgb = e_de ? color_of(hd) : 24'd0;
            end else begin
                e_de = 0; e_hs = 1; e_vsy = 1; e_rgb = 24'd0;
            end
            chk("rdaddr", rowram_rdaddr,
                (h < 640) ? (h / 2) : 0);
            chk("swap", rowram_swap, e_swap);
            chk("vblank_start", vblank_start, e_vs);
            chk("vblank_end", vblank_end, e_ve);
            chk("de", hdmi_de, e_de);
            chk("hsync", hdmi_hsync, e_hs);
            chk("vsync", hdmi_vsync, e_vsy);
            chk("rgb", hdmi_rgb, e_rgb);
            if (!hdmi_de)
                chk("rgb_blank", hdmi_rgb, 0);

            if (rowram_swap) swap_cnt[phase]++;
            if (vblank_end && vend_n[phase] < 0) vend_n[phase] = n;
            if (phase == 0) begin
                if (hdmi_de && first_de_n < 0) first_de_n = n;
                if (prev_hs && !hdmi_hsync && first_hs_fall_n < 0)
                    first_hs_fall_n = n;
                if (!hdmi_vsync) vs_low_cnt++;
                if (n >= 800 && n < 1600 && !hdmi_hsync) hs_low_line1++;
                if (n >= 36003 && n < 36803 && hdmi_de) de_line0++;
                if (n == 36003) rgb_x0 = hdmi_rgb;
                if (n == 36006) rgb_x3 = hdmi_rgb;
            end
            prev_hs = hdmi_hsync;
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Run until the raster sits at line 20, pixel 300.
        guard = 0;
        while (n != 52300 && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_line20", n, 52300);

        chk("first_vblank_end_n", vend_n[0], 33600);
        chk("first_de_n", first_de_n, 36003);
        chk("first_hsync_fall_n", first_hs_fall_n, 659);
        chk("vsync_low_cycles", vs_low_cnt, 1600);
        chk("hsync_low_cycles", hs_low_line1, 96);
        chk("de_per_line", de_line0, 640);
        chk("rgb_x0", rgb_x0, 24'h400000);
        chk("rgb_x3", rgb_x3, 24'h800001);
        chk("swaps_before_reset", swap_cnt[0], 11);

        // Mid-frame reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        phase = 1;
        #3;
        chk("post_reset_rgb", hdmi_rgb, 0);
        chk("post_reset_de", hdmi_de, 0);
        chk("post_reset_rdaddr", rowram_rdaddr, 0);
        repeat (33610) @(negedge clk);
        chk("vblank_end_after_reset", vend_n[1], 33600);
        chk("no_swap_in_vblank", swap_cnt[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdmi_scanout.md
# hdmi_scanout

- Upstream video front end of the PPU: generates 640x480@60 raster timing on the pixel clock.
- Scans the PPU's double-buffered row RAM, doubling each 320x240 PPU pixel 2x2, and resolves row-RAM entries through palette RAM into 24-bit RGB.
- Produces the `rowram_swap`, `vblank_start` and `vblank_end` pulses that drive the PPU frame FSM, plus the HDMI transmitter's pixel/sync stream.

## Interface
Parameters:
- None. Timing constants come from the shared package.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `rowram_rdaddr` out 9: PPU pixel column 0..319 to read.
- `rowram_rddata` in 10: row-RAM entry, valid 1 cycle after address.
  - [9:1] palette word address.
  - [0] half select.
- `palram_rdaddr` out 9: palette word address.
- `palram_rddata` in 64: palette word, valid 1 cycle after address.
  - [23:0] color for half 0.
  - [55:32] color for half 1.
- `rowram_swap` out 1: one-cycle pulse; PPU swaps front/back row buffers.
- `vblank_start` out 1: one-cycle pulse at first blank line.
- `vblank_end` out 1: one-cycle pulse opening the PPU display window.
- `hdmi_rgb` out 24: pixel color {R,G,B}.
- `hdmi_hsync` out 1: active-low horizontal sync.
- `hdmi_vsync` out 1: active-low vertical sync.
- `hdmi_de` out 1: data enable.

## Operation
Counters:
- `hcount` (10b) runs 0..799.
- `vcount` (10b) runs 0..524.
- `vcount` advances when `hcount` wraps; `vcount` 524 wraps to 0.

Horizontal timing:
- Active 0..639.
- Front porch 640..655.
- Sync 656..751.
- Back porch 752..799.

Vertical timing:
- Active 0..479.
- Front porch 480..489.
- Sync 490..491.
- Back porch 492..524.

Pipeline, stage 0 (counters):
- `rowram_rdaddr` = `hcount[9:1]` when `hcount` < 640, else 0.
- Driven directly from the counter registers.

Pipeline, stage 1:
- `palram_rdaddr` = `rowram_rddata[9:1]`, combinational.
- `rowram_rddata[0]` is registered into the select pipe.

Pipeline, stage 2:
- The selected 24-bit half of `palram_rddata` is registered into `hdmi_rgb`.
- `hdmi_rgb` is forced to 0 when the delayed DE is low.

Sync and DE alignment:
- DE = `hcount` < 640 && `vcount` < 480, computed from the stage-0 counters.
- hsync and vsync are computed from the stage-0 counters.
- DE, hsync and vsync pass through a 3-deep delay line so they stay aligned with `hdmi_rgb`.

Row doubling:
- PPU row r is displayed on lines 2r and 2r+1.

`rowram_swap` schedule:
- Pulses in the cycle where `hcount`==0 and `vcount` is in {524, 2, 4, …, 478}.
- That is 240 pulses per frame.
- It never pulses at `vcount` 480.

Vblank pulses:
- `vblank_start` pulses when `hcount`==0 and `vcount`==480.
- `vblank_end` pulses when `hcount`==0 and `vcount`==522.
- This leaves lines 522–523 for the PPU to render row 0 before the swap at line 524.

Pulse generation:
- All three pulses are registered outputs.
- Each is computed from a compare made one cycle early (`hcount`==799 on the preceding line).
- No combinational path from the counters to the pulses.

## Timing
Reset values:
- `hcount`=0, `vcount`=480. The first frame begins in vblank, so no partial frame is shown.
- `hdmi_rgb`=0, `hdmi_de`=0, `hdmi_hsync`=1, `hdmi_vsync`=1.
- `rowram_swap`, `vblank_start`, `vblank_end` = 0.
- Delay line cleared to blank/inactive.
- No `vblank_start` pulse on the cycle leaving reset.

Latency:
- 3 cycles from counter value to `hdmi_*`.
- Pixel x=0 appears on `hdmi_rgb` 3 cycles after `hcount`==0.

Pulse rules:
- Each pulse is high exactly one cycle.
- `rowram_swap` and `vblank_end` never coincide.
- `vblank_start` and `rowram_swap` never coincide.

Frame period:
- 420000 cycles.
- `vblank_start` to `vblank_end` = 42×800 = 33600 cycles.

Reset mid-frame:
- Restarts at (h=0, v=480) on the next cycle.
- All in-flight pipeline data is discarded.

Arithmetic:
- Counters compare against package constants only.
- No width truncation except `hcount[9:1]`.

## Structure
`video_pkg` holds:
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, `H_TOTAL`.
- The V equivalents.
- `VBLANK_END_LINE`=522 and `SWAP_PRIME_LINE`=524.
- The RGB888 typedef.

Sub-module `raster_counter`:
- Contains the h/v counters, the early compares, and the registered pulse outputs.
- `hdmi_scanout` keeps the RAM address muxing, the palette half select, and the 3-stage alignment pipe.

## Test plan
1. Reset, then run 2 frames.
   - 420000 cycles between `vblank_start` pulses.
   - 240 `rowram_swap` pulses per frame.
   - `vblank_end` occurs 33600 cycles after `vblank_start`.
2. Row-RAM model returning `{col, col[0]}`; palette model returning color = address.
   - `hdmi_rgb` matches the model.
   - Each PPU column repeats on 2 consecutive DE pixels.
   - First DE pixel lands 3 cycles after `hcount`==0.
3. Check sync geometry.
   - hsync low for 96 cycles starting at pixel 656 (delayed by 3).
   - vsync low for 2 lines at lines 490–491.
   - DE high 640×480 per frame.
4. Blanking: return nonzero palette data during blanking.
   - `hdmi_rgb`==0 whenever `hdmi_de`==0.
5. Assert `rst` at line 100, pixel 300.
   - Next cycle: counters at (0,480); all outputs at reset values.
   - No spurious swap/vblank pulse.
   - Next `vblank_end` occurs 33600 cycles later.
6. Check swap ordering around line 524.
   - Swap at (0,524).
   - Next swap at (0,2).
   - No swap at (0,0) or (0,480).
